aes_inv_key_sched: RTL and testbench

Sequential AES-128 reverse key schedule for the decryption datapath. It takes the cipher key and runs the forward expansion iteratively to reach round key 10. It then emits round keys 10 down to 0, one per accepted handshake, by applying the inverse key-schedule recurrence. It sits between the key register and the inverse-round pipeline, and it replaces the fully unrolled 1408-bit expansion with a 128-bit working register.

---
 rtl/aes_pkg.sv | 70 +++++++
 rtl/aes_inv_key_sched_if.sv | 52 +++++
 rtl/aes_sub_word.sv | 17 +
 rtl/aes_inv_key_sched.sv | 157 +++++++++++++++
 tb/tb_aes_inv_key_sched.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the key-schedule blocks. The encrypt-side key
// expansion uses the same package.
//   NR, NK    : round count and key length in 32-bit words (AES-128)
//   state_t   : sequencer states of the reverse key schedule
//   sbox()    : FIPS-197 forward S-box lookup
//   rcon()    : round constant word {rc_i, 24'h0} for i = 1..10
//   rot_word(): cyclic left rotation of a word by one byte
// Words are big-endian: bits [0:7] hold the first byte.
// -----------------------------------------------------------------------------
package aes_pkg;

   localparam int NR = 10;
   localparam int NK = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      REV  = 2'd2
   } state_t;

   localparam logic [7:0] SBOX_TABLE [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[b];
   endfunction

   // Index 0 and anything above NR return a zero word; the schedule never
   // consumes those values.
   function automatic logic [0:31] rcon(input logic [3:0] i);
      logic [7:0] rc;
      case (i)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return {rc, 24'h0};
   endfunction

   function automatic logic [0:31] rot_word(input logic [0:31] w);
      return {w[8:31], w[0:7]};
   endfunction

endpackage

// File: rtl/aes_inv_key_sched_if.sv
// -----------------------------------------------------------------------------
// aes_inv_key_sched_if
// Request / round-key stream bundle for the reverse key schedule.
//   start      : request pulse (master -> slave), sampled only while idle
//   start_last : load key_in as round key 10 directly (only when
//                AES_INV_KEY_LAST_EN is defined)
//   key_in     : cipher key, or round key 10 with start_last, byte 0 in [0:7]
//   busy       : schedule is active
//   rk_valid   : rk_out/rk_idx/rk_last carry a round key
//   rk_ready   : consumer accepts the current round key
//   rk_out     : round key, words w0..w3 in [0:31]..[96:127]
//   rk_idx     : round index of rk_out, 10 down to 0
//   rk_last    : marks round key 0
// Modports: master = key source / round-key consumer, slave = schedule.
// -----------------------------------------------------------------------------
interface aes_inv_key_sched_if;

   logic          start;
`ifdef AES_INV_KEY_LAST_EN
   logic          start_last;
`endif
   logic [0:127]  key_in;
   logic          busy;
   logic          rk_valid;
   logic          rk_ready;
   logic [0:127]  rk_out;
   logic [3:0]    rk_idx;
   logic          rk_last;

`ifdef AES_INV_KEY_LAST_EN
   modport master (
      output start, start_last, key_in, rk_ready,
      input  busy, rk_valid, rk_out, rk_idx, rk_last
   );

   modport slave (
      input  start, start_last, key_in, rk_ready,
      output busy, rk_valid, rk_out, rk_idx, rk_last
   );
`else
   modport master (
      output start, key_in, rk_ready,
      input  busy, rk_valid, rk_out, rk_idx, rk_last
   );

   modport slave (
      input  start, key_in, rk_ready,
      output busy, rk_valid, rk_out, rk_idx, rk_last
   );
`endif

endinterface

// File: rtl/aes_sub_word.sv
// -----------------------------------------------------------------------------
// aes_sub_word
// Combinational SubWord: applies the AES S-box to each byte of a word.
//   i_word : 32-bit input word, byte 0 in [0:7]
//   o_word : substituted word, same byte order
// -----------------------------------------------------------------------------
module aes_sub_word
   import aes_pkg::*;
(
   input  logic [0:31] i_word,
   output logic [0:31] o_word
);

   assign o_word = {sbox(i_word[0:7]),   sbox(i_word[8:15]),
                    sbox(i_word[16:23]), sbox(i_word[24:31])};

endmodule

// File: rtl/aes_inv_key_sched.sv
// -----------------------------------------------------------------------------
// aes_inv_key_sched
// Sequential AES-128 reverse key schedule. A start request loads the cipher
// key, ten forward expansion steps reach round key 10, and the block then
// streams round keys 10 down to 0 over a valid/ready handshake, undoing one
// expansion step per accepted key. One 128-bit working register and a single
// SubWord instance serve both directions.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : aes_inv_key_sched_if.slave (request, key and round-key stream)
// Build option: AES_INV_KEY_LAST_EN adds bus.start_last, which loads key_in
// as round key 10 and starts streaming on the next cycle.
// -----------------------------------------------------------------------------
module aes_inv_key_sched
   import aes_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   aes_inv_key_sched_if.slave   bus
);

   state_t              r_state;
   logic [3:0]          r_ctr;
   logic [0:NK*32-1]    r_key;
   logic                r_busy;
   logic                r_valid;
   logic                r_last;
   logic [3:0]          r_idx;

   logic [0:31]         w_w0, w_w1, w_w2, w_w3;
   logic [0:31]         w_sub_in, w_sub_out;
   logic [0:31]         w_t;
   logic [0:31]         w_f0, w_f1, w_f2, w_f3;
   logic [0:31]         w_r0, w_r1, w_r2, w_r3;
   logic                w_fire;
   logic                w_start_last;

   assign w_w0 = r_key[0:31];
   assign w_w1 = r_key[32:63];
   assign w_w2 = r_key[64:95];
   assign w_w3 = r_key[96:127];

`ifdef AES_INV_KEY_LAST_EN
   assign w_start_last = bus.start_last;
`else
   assign w_start_last = 1'b0;
`endif

   assign w_fire = r_valid & bus.rk_ready;

   // Inverse step, upper three words: each is recovered from two words of the
   // current round key, so they need no S-box.
   assign w_r3 = w_w3 ^ w_w2;
   assign w_r2 = w_w2 ^ w_w1;
   assign w_r1 = w_w1 ^ w_w0;

   // The forward step substitutes the current w3; the inverse step substitutes
   // the previous round's w3, which only exists after the XOR above.
   // NOTE: every variable written in an always_comb gets a default first, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_sub_in = rot_word(w_w3);
      if (r_state == REV) begin
         w_sub_in = rot_word(w_r3);
      end
   end

   aes_sub_word u_sub_word (
      .i_word (w_sub_in),
      .o_word (w_sub_out)
   );

   // Forward step with round constant ctr.
   assign w_t  = w_sub_out ^ rcon(r_ctr);
   assign w_f0 = w_w0 ^ w_t;
   assign w_f1 = w_w1 ^ w_f0;
   assign w_f2 = w_w2 ^ w_f1;
   assign w_f3 = w_w3 ^ w_f2;

   // Inverse step, word 0, with round constant of the key being retired.
   assign w_r0 = w_w0 ^ w_sub_out ^ rcon(r_idx);

   // NOTE: state is updated with non-blocking assignments only, so every
   // right-hand side above sees the values from before this clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the working register is reset as well, because it drives
         // rk_out directly and rk_out must read zero out of reset.
         r_state <= IDLE;
         r_ctr   <= '0;
         r_key   <= '0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_idx   <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_start_last) begin
                  r_key   <= bus.key_in;
                  r_idx   <= 4'(NR);
                  r_valid <= 1'b1;
                  r_last  <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= REV;
               end else if (bus.start) begin
                  r_key   <= bus.key_in;
                  r_ctr   <= 4'd1;
                  r_busy  <= 1'b1;
                  r_state <= FWD;
               end
            end

            FWD: begin
               // Steps run with ctr 1..NR; the cycle after the last step
               // (ctr = NR+1) publishes round key NR, so the first key
               // appears 11 cycles after the request is accepted.
               if (r_ctr == 4'(NR + 1)) begin
                  r_idx   <= 4'(NR);
                  r_valid <= 1'b1;
                  r_last  <= 1'b0;
                  r_state <= REV;
               end else begin
                  r_key <= {w_f0, w_f1, w_f2, w_f3};
                  r_ctr <= r_ctr + 4'd1;
               end
            end

            REV: begin
               if (w_fire) begin
                  if (r_idx == 4'd0) begin
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                     r_busy  <= 1'b0;
                     r_state <= IDLE;
                  end else begin
                     r_key  <= {w_r0, w_r1, w_r2, w_r3};
                     r_idx  <= r_idx - 4'd1;
                     r_last <= (r_idx == 4'd1);
                  end
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = r_busy;
   assign bus.rk_valid = r_valid;
   assign bus.rk_out   = r_key;
   assign bus.rk_idx   = r_idx;
   assign bus.rk_last  = r_last;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// -----------------------------------------------------------------------------
// tb_aes_inv_key_sched
// Self-checking bench for aes_inv_key_sched. A forward key expansion model
// fills a scoreboard with the expected round-key stream (10 down to 0); each
// accepted round key is popped and compared. Known FIPS-197 values are held
// in a vector table. Inputs are driven and outputs sampled on the falling
// clock edge. With AES_INV_KEY_LAST_EN defined the direct-load path is
// exercised as well.
// -----------------------------------------------------------------------------
module tb_aes_inv_key_sched;
   import aes_pkg::*;

   localparam logic [0:127] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [0:127] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [0:127] FIPS_RK9  = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [0:127] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   typedef struct {
      logic [3:0]   idx;
      logic [0:127] rk;
      logic         last;
   } exp_t;

   typedef struct {
      string        name;
      logic [0:127] key;
      int           idx;
      logic [0:127] rk;
   } vec_t;

   logic clk;
   logic rst;

   aes_inv_key_sched_if bus ();

   aes_inv_key_sched dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int           checks;
   int           failures;
   exp_t         sb_q [$];
   logic [0:127] gold [11];
   logic [0:127] obs  [11];
   logic [7:0]   rc_tab [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Forward expansion model: builds all eleven round keys from a cipher key.
   task automatic build_gold(input logic [0:127] key);
      logic [0:31] w [44];
      logic [0:31] t;
      for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[8:31], t[0:7]};
            t = {sbox(t[0:7]), sbox(t[8:15]), sbox(t[16:23]), sbox(t[24:31])};
            t[0:7] = t[0:7] ^ rc_tab[i/4];
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) gold[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // One complete request. key is driven on key_in, gold_key is the cipher
   // key the expected stream derives from. rst_at >= 0 asserts reset when
   // that round index is presented and ends the sequence there.
   task automatic run_seq(input logic [0:127] key, input logic [0:127] gold_key,
                          input bit rand_ready, input bit poke, input int rst_at,
                          input bit use_last);
      int           lat;
      int           edges;
      int           fires;
      int           cyc;
      int           partial;
      bit           stalled;
      logic [0:127] held_rk;
      logic [3:0]   held_idx;
      logic         held_last;
      exp_t         e;

      build_gold(gold_key);
      for (int i = NR; i >= 0; i--) sb_q.push_back('{idx: 4'(i), rk: gold[i], last: (i == 0)});
      for (int i = 0; i < 11; i++) obs[i] = 'x;

      bus.key_in   = key;
      bus.start    = 1'b1;
`ifdef AES_INV_KEY_LAST_EN
      bus.start_last = use_last;
`endif
      bus.rk_ready = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
`ifdef AES_INV_KEY_LAST_EN
      bus.start_last = 1'b0;
`endif

      // Edges after the accepting edge until the first key is presented.
      lat = 0;
      while (!bus.rk_valid && lat < 40) begin
         bus.start  = poke && (lat == 5);
         bus.key_in = bus.start ? ~key : key;
         @(negedge clk);
         lat++;
      end
      bus.start  = 1'b0;
      bus.key_in = key;
      check("first_key_latency", 128'(lat), 128'(use_last ? 0 : 11));
      check("busy_while_streaming", 128'(bus.busy), 128'(1));

      edges   = lat;
      fires   = 0;
      cyc     = 0;
      stalled = 1'b0;
      while (fires < 11 && cyc < 400 && bus.rk_valid) begin
         if (stalled) begin
            check("stall_rk_out", bus.rk_out, held_rk);
            check("stall_rk_idx", 128'(bus.rk_idx), 128'(held_idx));
            check("stall_rk_last", 128'(bus.rk_last), 128'(held_last));
         end

         if (rst_at >= 0 && int'(bus.rk_idx) == rst_at) begin
            rst          = 1'b1;
            bus.rk_ready = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            check("rst_busy", 128'(bus.busy), 128'(0));
            check("rst_rk_valid", 128'(bus.rk_valid), 128'(0));
            check("rst_rk_out", bus.rk_out, 128'h0);
            check("rst_rk_idx", 128'(bus.rk_idx), 128'(0));
            check("rst_rk_last", 128'(bus.rk_last), 128'(0));
            bus.rk_ready = 1'b1;
            partial = 0;
            for (int i = 0; i < 6; i++) begin
               @(negedge clk);
               if (bus.rk_valid || bus.busy) partial++;
            end
            check("no_key_after_rst", 128'(partial), 128'(0));
            sb_q.delete();
            return;
         end

         bus.start    = poke && (fires == 3);
         bus.key_in   = bus.start ? ~key : key;
         bus.rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus.rk_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_extra_key: got idx %0d with nothing expected", bus.rk_idx);
            end else begin
               e = sb_q.pop_front();
               check("rk_out", bus.rk_out, e.rk);
               check("rk_idx", 128'(bus.rk_idx), 128'(e.idx));
               check("rk_last", 128'(bus.rk_last), 128'(e.last));
            end
            obs[int'(bus.rk_idx)] = bus.rk_out;
            fires++;
            stalled = 1'b0;
         end else begin
            stalled   = 1'b1;
            held_rk   = bus.rk_out;
            held_idx  = bus.rk_idx;
            held_last = bus.rk_last;
         end
         @(negedge clk);
         edges++;
         cyc++;
      end
      bus.start    = 1'b0;
      bus.key_in   = key;
      bus.rk_ready = 1'b1;

      check("fire_count", 128'(fires), 128'(11));
      check("busy_after_last", 128'(bus.busy), 128'(0));
      check("valid_after_last", 128'(bus.rk_valid), 128'(0));
      if (!rand_ready) check("total_cycles", 128'(edges), 128'(use_last ? 11 : 22));
      sb_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         vecs [5];
      logic [0:127] rand_key;

      vecs[0] = '{name: "fips_rk10", key: FIPS_KEY,  idx: 10, rk: FIPS_RK10};
      vecs[1] = '{name: "fips_rk9",  key: FIPS_KEY,  idx: 9,  rk: FIPS_RK9};
      vecs[2] = '{name: "fips_rk0",  key: FIPS_KEY,  idx: 0,  rk: FIPS_KEY};
      vecs[3] = '{name: "zero_rk10", key: 128'h0,    idx: 10, rk: ZERO_RK10};
      vecs[4] = '{name: "zero_rk0",  key: 128'h0,    idx: 0,  rk: 128'h0};

      checks       = 0;
      failures     = 0;
      bus.start    = 1'b0;
`ifdef AES_INV_KEY_LAST_EN
      bus.start_last = 1'b0;
`endif
      bus.key_in   = '0;
      bus.rk_ready = 1'b0;

      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_busy", 128'(bus.busy), 128'(0));
      check("reset_rk_valid", 128'(bus.rk_valid), 128'(0));
      check("reset_rk_last", 128'(bus.rk_last), 128'(0));
      check("reset_rk_idx", 128'(bus.rk_idx), 128'(0));
      check("reset_rk_out", bus.rk_out, 128'h0);
      rst = 1'b0;
      @(negedge clk);

      // Known-answer table; runs are back to back, so each start lands in
      // the cycle right after the previous sequence finished.
      for (int v = 0; v < 5; v++) begin
         run_seq(vecs[v].key, vecs[v].key, 1'b0, 1'b0, -1, 1'b0);
         check(vecs[v].name, obs[vecs[v].idx], vecs[v].rk);
      end

      // Random backpressure on random keys.
      for (int n = 0; n < 3; n++) begin
         rand_key = {$urandom, $urandom, $urandom, $urandom};
         run_seq(rand_key, rand_key, 1'b1, 1'b0, -1, 1'b0);
         check("bp_rk0_is_key", obs[0], rand_key);
      end

      // start pulses during FWD and REV must be ignored.
      run_seq(FIPS_KEY, FIPS_KEY, 1'b0, 1'b1, -1, 1'b0);
      check("poke_rk10", obs[10], FIPS_RK10);
      check("poke_rk0", obs[0], FIPS_KEY);

      // Reset while round key 5 is presented, then a fresh full sequence.
      run_seq(FIPS_KEY, FIPS_KEY, 1'b0, 1'b0, 5, 1'b0);
      run_seq(FIPS_KEY, FIPS_KEY, 1'b1, 1'b0, -1, 1'b0);
      check("post_rst_rk9", obs[9], FIPS_RK9);
      check("post_rst_rk0", obs[0], FIPS_KEY);

`ifdef AES_INV_KEY_LAST_EN
      // Direct load of round key 10; start is also high and must lose.
      run_seq(FIPS_RK10, FIPS_KEY, 1'b0, 1'b0, -1, 1'b1);
      check("last_en_rk10", obs[10], FIPS_RK10);
      check("last_en_rk0", obs[0], FIPS_KEY);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
